// File: rtl/chunked_adder_seq_pkg.sv
// Shared types and elaboration helpers for the chunked sequential adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Constant function so the index register can be sized at elaboration.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    while ((64'd1 << bits) < 64'(value)) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/chunked_adder_seq_ripple_add_chunk.sv
// Combinational CHUNK-bit ripple-carry adder used for one slice per cycle.
module ripple_add_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
  end

  assign cout = carry[CHUNK];

endmodule

// File: rtl/chunked_adder_seq.sv
// Multi-cycle WIDTH-bit add/subtract unit processing one CHUNK-bit slice per
// clock, LSB first, behind a start/ready/done handshake.
module chunked_adder_seq
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("chunked_adder_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t            state, state_next;
  logic [WIDTH-1:0]  a_reg, b_reg, sum_reg, sum_next;
  logic              carry, cout_reg, ovf_reg;
  logic [IDXW-1:0]   idx;
  logic [CHUNK-1:0]  a_slice, b_slice, slice_sum;
  logic              slice_cout;
  logic              accept, last;

  assign accept = (state == IDLE) && start;
  assign last   = (idx == IDXW'(NCHUNK - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
  end

  // Slice mux: select the operand chunk addressed by the running index.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx == IDXW'(i)) begin
        a_slice = a_reg[i*CHUNK +: CHUNK];
        b_slice = b_reg[i*CHUNK +: CHUNK];
      end
    end
  end

  ripple_add_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a   (a_slice),
    .b   (b_slice),
    .cin (carry),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  always_comb begin
    sum_next = sum_reg;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx == IDXW'(i)) sum_next[i*CHUNK +: CHUNK] = slice_sum;
    end
  end

  // B is stored pre-inverted in subtract mode so RUN only ever adds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= sub ? ~b : b;
      carry   <= sub ? 1'b1 : cin;
      idx     <= '0;
      sum_reg <= '0;
    end else if (state == RUN) begin
      sum_reg <= sum_next;
      carry   <= slice_cout;
      if (last) begin
        idx      <= '0;
        cout_reg <= slice_cout;
        ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                    (slice_sum[CHUNK-1] != a_reg[WIDTH-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Directed bench for chunked_adder_seq (16/4 build plus a 16/16 build).
module tb_chunked_adder_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sub, cin;
  logic [15:0] a, b;
  logic        ready, done, cout, ovf;
  logic [15:0] sum;

  logic        start2, sub2, cin2;
  logic [15:0] a2, b2;
  logic        ready2, done2, cout2, ovf2;
  logic [15:0] sum2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chunked_adder_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .ready(ready), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  chunked_adder_seq #(.WIDTH(16), .CHUNK(16)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2), .cin(cin2),
    .ready(ready2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  // Issue one op on the 16/4 unit; returns with the bench in the done cycle.
  task automatic op1(input logic s, input logic [15:0] x, input logic [15:0] y,
                     input logic c, output int lat);
    @(negedge clk);
    sub = s; a = x; b = y; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = ~c;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op2(input logic [15:0] x, input logic [15:0] y, input logic c,
                     output int lat);
    @(negedge clk);
    sub2 = 1'b0; a2 = x; b2 = y; cin2 = c; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; a2 = '0; b2 = '0;
    lat = 0;
    while (done2 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL rst_sum got %h exp 0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL rst_cout got %b exp 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf); end
    checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL rst_ready2 got %b exp 1", ready2); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rst_idle got ready=%b done=%b exp 1/0", ready, done); end
  endtask

  task automatic test_basic_add();
    int lat;
    op1(1'b0, 16'h00FF, 16'h0001, 1'b0, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL t1_latency got %0d exp 4", lat); end
    checks++; if (sum !== 16'h0100) begin errors++; $display("FAIL t1_sum got %h exp 0100", sum); end
    checks++; if (cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL t1_flags got c=%b v=%b exp 0/0", cout, ovf); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL t1_ready_in_done got %b exp 0", ready); end
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL t1_pulse got done=%b ready=%b exp 0/1", done, ready); end
    checks++; if (sum !== 16'h0100) begin errors++; $display("FAIL t1_hold got %h exp 0100", sum); end
  endtask

  task automatic test_carry_ovf();
    int lat;
    op1(1'b0, 16'hFFFF, 16'h0001, 1'b0, lat);
    checks++; if (sum !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL t2_wrap got %h c=%b v=%b exp 0000 1 0", sum, cout, ovf); end
    op1(1'b0, 16'h7FFF, 16'h0001, 1'b0, lat);
    checks++; if (sum !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1) begin errors++; $display("FAIL t2_ovf got %h c=%b v=%b exp 8000 0 1", sum, cout, ovf); end
    op1(1'b0, 16'h1234, 16'h4321, 1'b1, lat);
    checks++; if (sum !== 16'h5556 || cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL t2_cin got %h c=%b v=%b exp 5556 0 0", sum, cout, ovf); end
  endtask

  task automatic test_subtract();
    int lat;
    op1(1'b1, 16'h0005, 16'h0007, 1'b1, lat);
    checks++; if (sum !== 16'hFFFE || cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL t3_borrow got %h c=%b v=%b exp FFFE 0 0", sum, cout, ovf); end
    op1(1'b1, 16'h8000, 16'h0001, 1'b0, lat);
    checks++; if (sum !== 16'h7FFF || cout !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL t3_ovf got %h c=%b v=%b exp 7FFF 1 1", sum, cout, ovf); end
  endtask

  task automatic test_back_to_back();
    int lat, pulses, ready_bad, extra;
    @(negedge clk);
    sub = 1'b0; a = 16'h0F0F; b = 16'h0101; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    lat = 0; ready_bad = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (ready !== 1'b0) ready_bad++;
      a = 16'($urandom); b = 16'($urandom); sub = 1'b1; cin = 1'b1;
      @(negedge clk);
      lat++;
    end
    pulses = (done === 1'b1) ? 1 : 0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL t4_ready_done got %b exp 0", ready); end
    checks++; if (sum !== 16'h1010 || cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL t4_sum got %h c=%b v=%b exp 1010 0 0", sum, cout, ovf); end
    checks++; if (lat != 4 || ready_bad != 0) begin errors++; $display("FAIL t4_run got lat=%0d ready_hi=%0d exp 4/0", lat, ready_bad); end
    start = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++; if (pulses + extra != 1) begin errors++; $display("FAIL t4_pulses got %0d exp 1", pulses + extra); end
  endtask

  task automatic test_reset_mid_run();
    int lat, pulses;
    op1(1'b0, 16'h7FFF, 16'h0001, 1'b0, lat);
    @(negedge clk);
    sub = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (sum !== 16'h0003) begin errors++; $display("FAIL t5_partial got %h exp 0003", sum); end
    rst = 1'b1;
    #1;
    checks++; if (sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL t5_rst_out got %h c=%b v=%b exp 0000 0 0", sum, cout, ovf); end
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL t5_rst_hs got ready=%b done=%b exp 1/0", ready, done); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL t5_no_done got %0d exp 0", pulses); end
    op1(1'b0, 16'h1111, 16'h2222, 1'b0, lat);
    checks++; if (lat != 4 || sum !== 16'h3333) begin errors++; $display("FAIL t5_recover got lat=%0d sum=%h exp 4 3333", lat, sum); end
  endtask

  task automatic test_single_chunk();
    int lat;
    logic [15:0] x, y;
    logic        c;
    logic [16:0] ref_full;
    logic        ref_ovf;
    op2(16'h1234, 16'h4321, 1'b0, lat);
    checks++; if (lat != 1 || sum2 !== 16'h5555) begin errors++; $display("FAIL t6_direct got lat=%0d sum=%h exp 1 5555", lat, sum2); end
    for (int n = 0; n < 8; n++) begin
      x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
      ref_full = {1'b0, x} + {1'b0, y} + {16'b0, c};
      ref_ovf  = (x[15] == y[15]) && (ref_full[15] != x[15]);
      op2(x, y, c, lat);
      checks++;
      if (lat != 1 || sum2 !== ref_full[15:0] || cout2 !== ref_full[16] || ovf2 !== ref_ovf) begin
        errors++;
        $display("FAIL t6_rand %h+%h+%b got lat=%0d %h c=%b v=%b exp 1 %h %b %b",
                 x, y, c, lat, sum2, cout2, ovf2, ref_full[15:0], ref_full[16], ref_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_ovf();
    test_subtract();
    test_back_to_back();
    test_reset_mid_run();
    test_single_chunk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
